// File: rtl/imm_extend_pkg.sv
// Purpose: shared immediate-extension mode encodings and stage storage states.
//   imm_mode_t       : 2-bit extension mode as driven by decode
//   IMM_SIGN/ZERO/UPPER/BRANCH : mode encodings
//   stage_state_e    : output-reg/skid occupancy (bit0 = out valid, bit1 = skid valid)
package imm_extend_pkg;

   typedef logic [1:0] imm_mode_t;

   localparam imm_mode_t IMM_SIGN   = 2'b00;
   localparam imm_mode_t IMM_ZERO   = 2'b01;
   localparam imm_mode_t IMM_UPPER  = 2'b10;
   localparam imm_mode_t IMM_BRANCH = 2'b11;

   // Encoded so the valid flags are direct register bits
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } stage_state_e;

endpackage

// File: rtl/imm_extend_core.sv
// Purpose: combinational widening of an IN_W-bit immediate to OUT_W bits.
// Ports:
//   i_imm     in  IN_W   raw immediate
//   i_mode    in  2      extension mode (SIGN/ZERO/UPPER/BRANCH)
//   o_value_c out  OUT_W  extended value (combinational)
module imm_extend_core
   import imm_extend_pkg::*;
#(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32
) (
   input  logic [IN_W-1:0]  i_imm,
   input  imm_mode_t        i_mode,
   output logic [OUT_W-1:0] o_value_c
);

   localparam int unsigned PAD_W = OUT_W - IN_W;

   // Upper placement needs room for the immediate plus IN_W zero bits
   if (OUT_W < 2 * IN_W) begin : g_bad_width
      $error("imm_extend_core: OUT_W must be >= 2*IN_W");
   end

   logic [OUT_W-1:0] w_sext;

   assign w_sext = {{PAD_W{i_imm[IN_W-1]}}, i_imm};

   // Mode select; branch drops the top two bits of the sign-extended value
   always_comb begin
      o_value_c = w_sext;
      case (i_mode)
         IMM_SIGN:   o_value_c = w_sext;
         IMM_ZERO:   o_value_c = OUT_W'(i_imm);
         IMM_UPPER:  o_value_c = OUT_W'({i_imm, {IN_W{1'b0}}});
         IMM_BRANCH: o_value_c = w_sext << 2;
         default:    o_value_c = w_sext;
      endcase
   end

endmodule

// File: rtl/imm_extend_stage.sv
// Purpose: registered immediate-extension stage between decode and execute,
//   valid/ready handshake with a 2-entry (output reg + skid) buffer.
// Optional: define IMM_EXT_PERF_EN to add the perf_stall_cnt output.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   flush                synchronous flush, drops all held and incoming values
//   in_valid/in_ready    input handshake (in_ready registered)
//   in_imm/in_mode/in_tag  immediate, extension mode, sideband tag
//   out_valid/out_ready  output handshake
//   out_data/out_tag     extended value and its tag
//   perf_stall_cnt       (IMM_EXT_PERF_EN) saturating count of stalled output cycles
module imm_extend_stage
   import imm_extend_pkg::*;
#(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  imm_mode_t        in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
`ifdef IMM_EXT_PERF_EN
   ,
   output logic [31:0]      perf_stall_cnt
`endif
);

   stage_state_e     r_state;
   stage_state_e     w_state_nxt;
   logic             r_in_ready;
   logic [OUT_W-1:0] r_out_data;
   logic [TAG_W-1:0] r_out_tag;
   logic [OUT_W-1:0] r_skid_data;
   logic [TAG_W-1:0] r_skid_tag;
   logic [OUT_W-1:0] w_ext;
   logic             w_accept;
   logic             w_load_out_new;
   logic             w_load_out_skid;
   logic             w_load_skid;

   imm_extend_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .i_imm     (in_imm),
      .i_mode    (in_mode),
      .o_value_c (w_ext)
   );

   assign w_accept  = in_valid & r_in_ready;
   assign in_ready  = r_in_ready;
   assign out_valid = r_state[0];
   assign out_data  = r_out_data;
   assign out_tag   = r_out_tag;

   // Occupancy next-state and register load enables; flush overrides everything
   always_comb begin
      w_state_nxt     = r_state;
      w_load_out_new  = 1'b0;
      w_load_out_skid = 1'b0;
      w_load_skid     = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt    = ST_ONE;
                  w_load_out_new = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_accept && out_ready) begin
                  w_load_out_new = 1'b1;
               end else if (w_accept) begin
                  w_state_nxt = ST_FULL;
                  w_load_skid = 1'b1;
               end else if (out_ready) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  w_state_nxt     = ST_ONE;
                  w_load_out_skid = 1'b1;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // State register; in_ready is registered as "skid will be empty"
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_FULL);
      end
   end

   // Data path registers; contents are left alone on flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_tag   <= '0;
         r_skid_data <= '0;
         r_skid_tag  <= '0;
      end else begin
         if (w_load_out_new) begin
            r_out_data <= w_ext;
            r_out_tag  <= in_tag;
         end else if (w_load_out_skid) begin
            r_out_data <= r_skid_data;
            r_out_tag  <= r_skid_tag;
         end
         if (w_load_skid) begin
            r_skid_data <= w_ext;
            r_skid_tag  <= in_tag;
         end
      end
   end

`ifdef IMM_EXT_PERF_EN
   logic [31:0] r_stall_cnt;

   // Saturating stall counter, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_imm_extend_stage.sv
// Purpose: self-checking bench for imm_extend_stage (IN_W=16, OUT_W=32, TAG_W=5).
//   Directed steps drive the stage; a negedge monitor keeps an expected-value
//   queue filled on accept and drained on each output handshake.
module tb_imm_extend_stage;
   import imm_extend_pkg::*;

   localparam int unsigned IN_W  = 16;
   localparam int unsigned OUT_W = 32;
   localparam int unsigned TAG_W = 5;

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic [TAG_W-1:0] tag;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   imm_mode_t        in_mode;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
`ifdef IMM_EXT_PERF_EN
   logic [31:0]      perf_stall_cnt;
`endif

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   imm_extend_stage #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .TAG_W (TAG_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imm    (in_imm),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
`ifdef IMM_EXT_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference extension written arithmetically
   function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] imm, input imm_mode_t mode);
      logic signed [OUT_W-1:0] s;
      s = OUT_W'($signed(imm));
      case (mode)
         IMM_SIGN:   return s;
         IMM_ZERO:   return {16'h0000, imm};
         IMM_UPPER:  return {imm, 16'h0000};
         default:    return s * 4;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [IN_W-1:0] imm, input imm_mode_t mode,
                        input logic [TAG_W-1:0] tag);
      in_valid = v;
      in_imm   = imm;
      in_mode  = mode;
      in_tag   = tag;
   endtask

   // Scoreboard: pop on output handshake, push on accept, drop everything on flush
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            check("sb_output_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
               exp_t e;
               e = q.pop_front();
               check("sb_data", 64'(out_data), 64'(e.data));
               check("sb_tag", 64'(out_tag), 64'(e.tag));
            end
         end
         if (flush) begin
            q.delete();
         end else if (in_valid && in_ready) begin
            q.push_back('{data: model(in_imm, in_mode), tag: in_tag});
         end
      end
   end

   // Hard stop so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, '0, IMM_SIGN, '0);
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      step();
      rst_n = 1'b1;

      // Mode vectors, streamed back to back with out_ready high
      drive(1'b1, 16'h8000, IMM_SIGN, 5'd1);
      step();
      check("sign_neg_valid", 64'(out_valid), 64'd1);
      check("sign_neg", 64'(out_data), 64'hFFFF_8000);
      drive(1'b1, 16'h7FFF, IMM_SIGN, 5'd2);
      step();
      check("sign_pos", 64'(out_data), 64'h0000_7FFF);
      drive(1'b1, 16'h8000, IMM_ZERO, 5'd3);
      step();
      check("zero", 64'(out_data), 64'h0000_8000);
      drive(1'b1, 16'h1234, IMM_UPPER, 5'd4);
      step();
      check("upper", 64'(out_data), 64'h1234_0000);
      drive(1'b1, 16'hFFFF, IMM_BRANCH, 5'd5);
      step();
      check("branch", 64'(out_data), 64'hFFFF_FFFC);
      check("branch_tag", 64'(out_tag), 64'd5);
      drive(1'b0, '0, IMM_SIGN, '0);
      step();
      check("modes_idle_valid", 64'(out_valid), 64'd0);

      // Backpressure: fill output reg and skid, then drain in order
      out_ready = 1'b0;
      drive(1'b1, 16'h0011, IMM_SIGN, 5'd3);
      step();
      check("bp_a_in_ready", 64'(in_ready), 64'd1);
      drive(1'b1, 16'h0022, IMM_ZERO, 5'd7);
      step();
      check("bp_full_in_ready", 64'(in_ready), 64'd0);
      check("bp_a_data", 64'(out_data), 64'h0000_0011);
      check("bp_a_tag", 64'(out_tag), 64'd3);
      drive(1'b0, '0, IMM_SIGN, '0);
      step();
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_data", 64'(out_data), 64'h0000_0011);
      check("bp_hold_tag", 64'(out_tag), 64'd3);
      out_ready = 1'b1;
      step();
      check("bp_b_data", 64'(out_data), 64'h0000_0022);
      check("bp_b_tag", 64'(out_tag), 64'd7);
      check("bp_b_in_ready", 64'(in_ready), 64'd1);
      step();
      check("bp_drained_valid", 64'(out_valid), 64'd0);

      // Back-to-back random stream: one output per cycle, in_ready never drops
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, IN_W'($urandom), imm_mode_t'($urandom_range(0, 3)), TAG_W'($urandom));
         step();
         check("stream_in_ready", 64'(in_ready), 64'd1);
         check("stream_out_valid", 64'(out_valid), 64'd1);
      end
      drive(1'b0, '0, IMM_SIGN, '0);
      step();
      check("stream_end_valid", 64'(out_valid), 64'd0);
      check("stream_sb_empty", 64'(q.size()), 64'd0);

      // Flush while full, with a competing input in the same cycle
      out_ready = 1'b0;
      drive(1'b1, 16'h0101, IMM_SIGN, 5'd10);
      step();
      drive(1'b1, 16'h0202, IMM_SIGN, 5'd11);
      step();
      check("fl_full_in_ready", 64'(in_ready), 64'd0);
      drive(1'b1, 16'h0303, IMM_SIGN, 5'd12);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, '0, IMM_SIGN, '0);
      check("fl_out_valid", 64'(out_valid), 64'd0);
      check("fl_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("fl_no_output", 64'(out_valid), 64'd0);
      end

      // Asynchronous reset in the middle of a held output
      out_ready = 1'b0;
      drive(1'b1, 16'h0404, IMM_ZERO, 5'd13);
      step();
      drive(1'b0, '0, IMM_SIGN, '0);
      check("ar_one_valid", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      q.delete();
      #1;
      check("ar_async_valid", 64'(out_valid), 64'd0);
      check("ar_async_in_ready", 64'(in_ready), 64'd1);
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("ar_no_output", 64'(out_valid), 64'd0);
      end

`ifdef IMM_EXT_PERF_EN
      // Stall counter: five stalled cycles, the last one under flush
      check("perf_after_reset", 64'(perf_stall_cnt), 64'd0);
      out_ready = 1'b0;
      drive(1'b1, 16'h0505, IMM_SIGN, 5'd14);
      step();
      drive(1'b0, '0, IMM_SIGN, '0);
      for (int i = 0; i < 4; i++) step();
      check("perf_four", 64'(perf_stall_cnt), 64'd4);
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      step();
      check("perf_after_flush", 64'(perf_stall_cnt), 64'd5);
      check("perf_flushed_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b0;
      #1;
      check("perf_reset", 64'(perf_stall_cnt), 64'd0);
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
`endif

      check("final_sb_empty", 64'(q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/imm_extend_stage.md
Name: imm_extend_stage

Overview:
- Parametrised, registered immediate-extension pipeline stage for the datapath. Next generation of the combinational 16-to-32 sign extender.
- Widens an IN_W-bit immediate to OUT_W bits in one of four modes: sign, zero, upper (LUI-style) and branch-offset (sign-extend, then shift left 2).
- Carries a TAG_W sideband with each immediate.
- Sits between decode and execute. Valid/ready handshake with a 2-entry skid buffer gives full throughput and a registered in_ready.

Parameters:
- IN_W, 16, immediate input width
- OUT_W, 32, extended output width; elaboration error unless OUT_W >= 2*IN_W
- TAG_W, 5, sideband tag width (e.g. destination register index)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  input immediate valid
- in_ready  out  1  stage can accept input
- in_imm  in  IN_W  raw immediate
- in_mode  in  2  00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts
- out_data  out  OUT_W  extended value
- out_tag  out  TAG_W  tag aligned with out_data

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: out_valid=0, out_data=0, out_tag=0, skid_valid=0, skid contents 0, in_ready=1.
- Extension rules:
  - SIGN: replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
  - ZERO: upper bits 0.
  - UPPER: in_imm in bits [2*IN_W-1:IN_W]; low IN_W bits 0; bits above 2*IN_W are 0.
  - BRANCH: sign-extend to OUT_W, then shift left 2; low 2 bits 0; top 2 bits discarded.
- Extension is computed combinationally on the input side. Only extended values are stored.
- Input handshake: accepted when in_valid & in_ready. Output handshake: completes when out_valid & out_ready.
- in_ready = ~skid_valid, driven from a register.
- Latency: 1 cycle from input acceptance to out_valid when the output register is empty or draining.
- Storage states (output reg / skid):
  - EMPTY (0/0)
  - ONE (1/0)
  - FULL (1/1)
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + out_ready -> ONE; output reg reloads with the new value.
  - ONE + accept + ~out_ready -> FULL; new value goes to skid.
  - ONE + ~accept + out_ready -> EMPTY.
  - FULL + out_ready -> ONE; skid moves to the output reg. No accept possible in FULL since in_ready=0.
- Ordering: strict FIFO; no value is dropped or duplicated.
- out_data and out_tag hold stable while out_valid & ~out_ready.
- flush (highest priority):
  - Next cycle out_valid=0, skid_valid=0, in_ready=1.
  - An input presented in the same cycle as flush is discarded.
  - Data registers keep their old values; they are don't-care while invalid.
- Reset asserted mid-operation clears all valids immediately, asynchronously. Nothing is emitted after release until a new accept.
- in_mode and in_tag are sampled only on accept.

Optional Feature:
- Macro IMM_EXT_PERF_EN.
- When defined:
  - Adds output port perf_stall_cnt, 32 bits.
  - Counts cycles with out_valid & ~out_ready.
  - Saturates at 0xFFFFFFFF.
  - Reset to 0 by rst_n only; flush does not clear it.
- When undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package: mode localparams IMM_SIGN=2'b00, IMM_ZERO=2'b01, IMM_UPPER=2'b10, IMM_BRANCH=2'b11, plus a 2-bit imm_mode_t typedef. Decode and the testbench reuse these.
- One natural sub-module: imm_extend_core, the purely combinational extension (IN_W, OUT_W, mode -> value).
- The skid/handshake logic stays in imm_extend_stage.

Test Plan:
- Modes, IN_W=16, OUT_W=32, out_ready=1:
  - SIGN 0x8000 -> 0xFFFF8000; SIGN 0x7FFF -> 0x00007FFF.
  - ZERO 0x8000 -> 0x00008000.
  - UPPER 0x1234 -> 0x12340000.
  - BRANCH 0xFFFF -> 0xFFFFFFFC.
  - Each appears one cycle after accept.
- Backpressure:
  - Hold out_ready=0; accept A (tag 3), then B (tag 7). in_ready=0 after B.
  - Raise out_ready: A/3 then B/7 on consecutive cycles. in_ready=1 the cycle after A leaves.
- Back-to-back streaming: 100 random accepts with out_ready=1 -> one output per cycle, in order, in_ready never drops.
- Flush when FULL, with in_valid=1 the same cycle -> next cycle out_valid=0, in_ready=1. The flushed-cycle input never appears.
- Reset: assert rst_n=0 while ONE, mid-cycle -> out_valid drops immediately. After release, no output until a new accept.
- IMM_EXT_PERF_EN: 5 cycles of out_valid & ~out_ready -> perf_stall_cnt=5. Flush leaves it at 5. rst_n clears it to 0.
